// File: rtl/rf_wb_ctrl.sv
// Register-file writeback controller: merges the pipeline writeback port with a
// 2-entry in-order FIFO of auxiliary writes. Pipeline writes have priority over FIFO drains.
module rf_wb_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_wa,
  input  logic [31:0] pipe_din,
  input  logic        aux_valid,
  output logic        aux_ready,
  input  logic [4:0]  aux_wa,
  input  logic [31:0] aux_din,
  output logic        RFWr,
  output logic [4:0]  wa,
  output logic [31:0] din,
  output logic [31:0] busy_mask,
  output logic        stall_req,
  output logic [1:0]  fifo_cnt,
  output logic        conflict_err
);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] din;
  } wb_req_t;

  wb_req_t    fifo_q [2];
  wb_req_t    win;
  logic       push;
  logic       pop;
  logic       win_valid;
  logic       wr_idx;
  logic [1:0] cnt_nxt;
  logic [2:0] age;

  assign aux_ready = (fifo_cnt != 2'd2);
  assign push      = aux_valid && aux_ready;
  assign pop       = !pipe_valid && (fifo_cnt != 2'd0);
  assign win_valid = pipe_valid || pop;
  assign win       = pipe_valid ? wb_req_t'{wa: pipe_wa, din: pipe_din} : fifo_q[0];
  // With a same-cycle pop the tail slides down one slot before the new entry lands.
  assign wr_idx    = (fifo_cnt == 2'd1) && !pop;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_nxt = fifo_cnt;
    if (push && !pop)
      cnt_nxt = fifo_cnt + 2'd1;
    else if (pop && !push)
      cnt_nxt = fifo_cnt - 2'd1;
  end

  always_comb begin
    busy_mask = '0;
    if (fifo_cnt != 2'd0)
      busy_mask[fifo_q[0].wa] = 1'b1;
    if (fifo_cnt == 2'd2)
      busy_mask[fifo_q[1].wa] = 1'b1;
    busy_mask[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RFWr         <= 1'b0;
      wa           <= '0;
      din          <= '0;
      fifo_cnt     <= '0;
      age          <= '0;
      stall_req    <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      RFWr     <= win_valid && (win.wa != 5'd0);
      if (win_valid) begin
        wa  <= win.wa;
        din <= win.din;
      end
      fifo_cnt <= cnt_nxt;
      if (pop || fifo_cnt == 2'd0)
        age <= '0;
      else if (age != 3'd7)
        age <= age + 3'd1;
      stall_req <= (fifo_cnt == 2'd2) || (age >= 3'd4);
      if (pipe_valid && stall_req)
        conflict_err <= 1'b1;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; fifo_cnt alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (pop)
      fifo_q[0] <= fifo_q[1];
    if (push)
      fifo_q[wr_idx] <= wb_req_t'{wa: aux_wa, din: aux_din};
  end

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Bench for rf_wb_ctrl: queue-based reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_rf_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_din;
  logic        aux_valid;
  logic        aux_ready;
  logic [4:0]  aux_wa;
  logic [31:0] aux_din;
  logic        RFWr;
  logic [4:0]  wa;
  logic [31:0] din;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic [1:0]  fifo_cnt;
  logic        conflict_err;

  int checks   = 0;
  int failures = 0;

  rf_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_wa(pipe_wa), .pipe_din(pipe_din),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_wa(aux_wa), .aux_din(aux_din),
    .RFWr(RFWr), .wa(wa), .din(din), .busy_mask(busy_mask),
    .stall_req(stall_req), .fifo_cnt(fifo_cnt), .conflict_err(conflict_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue, outputs follow the arbitration rules directly.
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] din;
  } req_t;

  req_t        m_q[$];
  logic        m_rfwr  = 1'b0;
  logic [4:0]  m_wa    = '0;
  logic [31:0] m_din   = '0;
  int          m_age   = 0;
  logic        m_stall = 1'b0;
  logic        m_conf  = 1'b0;

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (m_q[i])
      if (m_q[i].wa != 5'd0) b[m_q[i].wa] = 1'b1;
    return b;
  endfunction

  task automatic model_step();
    int   n;
    logic do_pop;
    logic do_push;
    logic stall_n;
    req_t h;
    if (rst) begin
      m_q.delete();
      m_rfwr = 1'b0; m_wa = '0; m_din = '0;
      m_age = 0; m_stall = 1'b0; m_conf = 1'b0;
      return;
    end
    n       = m_q.size();
    do_pop  = !pipe_valid && n > 0;
    do_push = aux_valid && n < 2;
    stall_n = (n == 2) || (m_age >= 4);
    if (pipe_valid && m_stall) m_conf = 1'b1;
    if (pipe_valid) begin
      m_wa = pipe_wa; m_din = pipe_din; m_rfwr = (pipe_wa != 0);
    end else if (do_pop) begin
      h = m_q.pop_front();
      m_wa = h.wa; m_din = h.din; m_rfwr = (h.wa != 0);
    end else begin
      m_rfwr = 1'b0;
    end
    if (do_pop || n == 0) m_age = 0;
    else if (m_age < 7)   m_age = m_age + 1;
    if (do_push) m_q.push_back('{wa: aux_wa, din: aux_din});
    m_stall = stall_n;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("m_RFWr",      {31'd0, RFWr},         {31'd0, m_rfwr});
    check("m_wa",        {27'd0, wa},           {27'd0, m_wa});
    check("m_din",       din,                   m_din);
    check("m_fifo_cnt",  {30'd0, fifo_cnt},     m_q.size());
    check("m_aux_ready", {31'd0, aux_ready},    {31'd0, m_q.size() < 2});
    check("m_busy_mask", busy_mask,             model_busy());
    check("m_stall_req", {31'd0, stall_req},    {31'd0, m_stall});
    check("m_conflict",  {31'd0, conflict_err}, {31'd0, m_conf});
  end

  // Drive one cycle of inputs, then land 1 time unit after the sampling edge.
  task automatic cyc(input logic pv, input logic [4:0] pwa, input logic [31:0] pd,
                     input logic av, input logic [4:0] awa, input logic [31:0] ad);
    pipe_valid = pv; pipe_wa = pwa; pipe_din = pd;
    aux_valid  = av; aux_wa  = awa; aux_din  = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 1'b0; pipe_wa = '0; pipe_din = '0;
    aux_valid  = 1'b0; aux_wa  = '0; aux_din  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_RFWr", {31'd0, RFWr}, 32'd0);
    check("rst_cnt",  {30'd0, fifo_cnt}, 32'd0);
    check("rst_busy", busy_mask, 32'd0);
    check("rst_ready", {31'd0, aux_ready}, 32'd1);

    // Aux write while idle, pushed at the first edge after reset release
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEAD);
    check("aux_cnt", {30'd0, fifo_cnt}, 32'd1);
    check("aux_busy", busy_mask, 32'h0000_0200);
    check("aux_rfwr0", {31'd0, RFWr}, 32'd0);
    idle();
    check("aux_rfwr", {31'd0, RFWr}, 32'd1);
    check("aux_wa", {27'd0, wa}, 32'd9);
    check("aux_din", din, 32'hDEAD);
    check("aux_busy_clr", busy_mask, 32'd0);

    // Pipe only, then pipe to r0
    cyc(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("pipe_rfwr", {31'd0, RFWr}, 32'd1);
    check("pipe_wa", {27'd0, wa}, 32'd5);
    check("pipe_din", din, 32'h1234);
    idle();
    check("pipe_idle", {31'd0, RFWr}, 32'd0);
    cyc(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0);
    check("pipe_r0_rfwr", {31'd0, RFWr}, 32'd0);
    check("pipe_r0_din", din, 32'h55);

    // Aux write to r0: consumed without a write strobe
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77);
    check("r0_cnt", {30'd0, fifo_cnt}, 32'd1);
    check("r0_busy", busy_mask, 32'd0);
    idle();
    check("r0_rfwr", {31'd0, RFWr}, 32'd0);
    check("r0_cnt0", {30'd0, fifo_cnt}, 32'd0);
    check("r0_din", din, 32'h77);

    // Fill under pipe pressure, conflict, then in-order drain
    cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd3, 32'h33);
    check("fill_cnt1", {30'd0, fifo_cnt}, 32'd1);
    cyc(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44);
    check("fill_cnt2", {30'd0, fifo_cnt}, 32'd2);
    check("fill_ready", {31'd0, aux_ready}, 32'd0);
    check("fill_busy", busy_mask, 32'h0000_0018);
    check("fill_pipe_wa", {27'd0, wa}, 32'd2);
    cyc(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
    check("fill_stall", {31'd0, stall_req}, 32'd1);
    check("fill_full_cnt", {30'd0, fifo_cnt}, 32'd2);
    check("fill_conf0", {31'd0, conflict_err}, 32'd0);
    cyc(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 32'd0);
    check("fill_conf1", {31'd0, conflict_err}, 32'd1);
    idle();
    check("drain1_wa", {27'd0, wa}, 32'd3);
    check("drain1_din", din, 32'h33);
    check("drain1_cnt", {30'd0, fifo_cnt}, 32'd1);
    idle();
    check("drain2_wa", {27'd0, wa}, 32'd4);
    check("drain2_din", din, 32'h44);
    check("drain2_cnt", {30'd0, fifo_cnt}, 32'd0);
    check("conf_sticky", {31'd0, conflict_err}, 32'd1);

    // Simultaneous push and pop
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hAAAA);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hBBBB);
    check("pp_wa", {27'd0, wa}, 32'd10);
    check("pp_cnt", {30'd0, fifo_cnt}, 32'd1);
    check("pp_busy", busy_mask, 32'h0000_0800);
    idle();
    check("pp_wa2", {27'd0, wa}, 32'd11);
    check("pp_din2", din, 32'hBBBB);

    // Starvation: one entry held back by continuous pipe writes
    cyc(1'b1, 5'd13, 32'h1313, 1'b1, 5'd12, 32'hC0C0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 32'd0);
      check("starve_nostall", {31'd0, stall_req}, 32'd0);
    end
    cyc(1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 32'd0);
    check("starve_stall", {31'd0, stall_req}, 32'd1);
    idle();
    check("starve_wa", {27'd0, wa}, 32'd12);
    check("starve_din", din, 32'hC0C0);
    idle();

    // Reset mid-drain
    cyc(1'b1, 5'd16, 32'h16, 1'b1, 5'd14, 32'hE);
    cyc(1'b1, 5'd17, 32'h17, 1'b1, 5'd15, 32'hF);
    check("mid_cnt2", {30'd0, fifo_cnt}, 32'd2);
    pipe_valid = 1'b0; aux_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_RFWr", {31'd0, RFWr}, 32'd0);
    check("mid_rst_wa", {27'd0, wa}, 32'd0);
    check("mid_rst_din", din, 32'd0);
    check("mid_rst_cnt", {30'd0, fifo_cnt}, 32'd0);
    check("mid_rst_busy", busy_mask, 32'd0);
    check("mid_rst_stall", {31'd0, stall_req}, 32'd0);
    check("mid_rst_conf", {31'd0, conflict_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle();
      check("post_rst_RFWr", {31'd0, RFWr}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
